// File: rtl/aes128_pack_fifo.sv
// Write-side 128->512 packer: four cipher blocks per cache line, show-ahead output.
// Optional flush padding of a partial line is enabled with `define AES128_PACK_FLUSH_EN.
module aes128_pack_fifo #(
  parameter int AES128_PACK_DEPTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [127:0]                       enq_data,
  input  logic                               enq_en,
  output logic                               not_full,
  output logic [511:0]                       deq_data,
  output logic [3:0]                         deq_mask,
  input  logic                               deq_en,
  output logic                               not_empty,
  input  logic                               flush,
  output logic [$clog2(AES128_PACK_DEPTH):0] counter,
  output logic [$clog2(AES128_PACK_DEPTH):0] free_count
);

  localparam int DEPTH = AES128_PACK_DEPTH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  logic [127:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_round;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] count_nxt;
  logic          enq_ok;
  logic          deq_ok;
  logic          flush_ok;

  assign not_full   = count < CW'(DEPTH);
  assign not_empty  = count >= CW'(4);
  assign enq_ok     = enq_en & not_full;
  assign deq_ok     = deq_en & not_empty;
  assign counter    = count;
  assign free_count = CW'(DEPTH) - count;
  assign wr_round   = (wr_ptr | PW'(3)) + PW'(1);

`ifdef AES128_PACK_FLUSH_EN
  logic [DEPTH-1:0] vld;

  // wr_ptr[1:0] tracks count[1:0] because rd_ptr stays quad-aligned.
  assign flush_ok = flush & ~enq_en & (count[1:0] != 2'b00);
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign flush_ok     = 1'b0;
`endif

  always_comb begin
    count_inc = '0;
    if (enq_ok)
      count_inc = CW'(1);
    else if (flush_ok)
      count_inc = CW'(3'd4 - {1'b0, count[1:0]});
    count_nxt = count + count_inc - (deq_ok ? CW'(4) : CW'(0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (enq_ok)
        wr_ptr <= wr_ptr + PW'(1);
      else if (flush_ok)
        wr_ptr <= wr_round;
      if (deq_ok)
        rd_ptr <= rd_ptr + PW'(4);
    end
  end

  // Storage is deliberately left out of reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      mem[wr_ptr] <= enq_data;
`ifdef AES128_PACK_FLUSH_EN
    end else if (flush_ok) begin
      for (int j = 0; j < 4; j++)
        if (2'(j) >= wr_ptr[1:0])
          mem[{wr_ptr[PW-1:2], 2'(j)}] <= '0;
`endif
    end
  end

`ifdef AES128_PACK_FLUSH_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else if (enq_ok) begin
      vld[wr_ptr] <= 1'b1;
    end else if (flush_ok) begin
      for (int j = 0; j < 4; j++)
        if (2'(j) >= wr_ptr[1:0])
          vld[{wr_ptr[PW-1:2], 2'(j)}] <= 1'b0;
    end
  end
`endif

  always_comb begin
    deq_data = '0;
    deq_mask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      deq_data[128*i +: 128] = mem[{rd_ptr[PW-1:2], 2'(i)}];
`ifdef AES128_PACK_FLUSH_EN
      deq_mask[i] = vld[{rd_ptr[PW-1:2], 2'(i)}];
`endif
    end
  end

endmodule

// File: tb/tb_aes128_pack_fifo.sv
// Self-checking bench for aes128_pack_fifo using a block-level scoreboard queue.
// Flush expectations follow `AES128_PACK_FLUSH_EN, matching the build of the DUT.
module tb_aes128_pack_fifo;

  localparam int DEPTH = 32;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [127:0]  enq_data;
  logic          enq_en;
  logic          not_full;
  logic [511:0]  deq_data;
  logic [3:0]    deq_mask;
  logic          deq_en;
  logic          not_empty;
  logic          flush;
  logic [CW-1:0] counter;
  logic [CW-1:0] free_count;

  int vectors    = 0;
  int miscompares = 0;

  logic [127:0] sb_data[$];
  bit           sb_vld[$];

  always #5 clk = ~clk;

  aes128_pack_fifo #(.AES128_PACK_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enq_data   (enq_data),
    .enq_en     (enq_en),
    .not_full   (not_full),
    .deq_data   (deq_data),
    .deq_mask   (deq_mask),
    .deq_en     (deq_en),
    .not_empty  (not_empty),
    .flush      (flush),
    .counter    (counter),
    .free_count (free_count)
  );

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [511:0] exp_line();
    return {sb_data[3], sb_data[2], sb_data[1], sb_data[0]};
  endfunction

  function automatic logic [3:0] exp_mask();
    return {sb_vld[3], sb_vld[2], sb_vld[1], sb_vld[0]};
  endfunction

  // Drives one cycle and updates the scoreboard with what the FIFO should accept.
  task automatic applyStimulus(input logic en, input logic [127:0] d,
                               input logic de, input logic fl);
    int n;
    bit acc_enq, acc_deq, fl_ok;
    n       = sb_data.size();
    acc_enq = en && (n < DEPTH);
    acc_deq = de && (n >= 4);
    fl_ok   = 1'b0;
`ifdef AES128_PACK_FLUSH_EN
    fl_ok = fl && !en && (n % 4 != 0);
`endif
    enq_en   = en;
    enq_data = d;
    deq_en   = de;
    flush    = fl;
    @(posedge clk);
    #1;
    enq_en = 1'b0;
    deq_en = 1'b0;
    flush  = 1'b0;
    if (acc_deq)
      repeat (4) begin
        void'(sb_data.pop_front());
        void'(sb_vld.pop_front());
      end
    if (acc_enq) begin
      sb_data.push_back(d);
      sb_vld.push_back(1'b1);
    end
    if (fl_ok)
      repeat (4 - n % 4) begin
        sb_data.push_back('0);
        sb_vld.push_back(1'b0);
      end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enq_en   = 1'b0;
    deq_en   = 1'b0;
    flush    = 1'b0;
    enq_data = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_data.delete();
    sb_vld.delete();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (counter !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_counter: got %0d expected 0", counter);
    end
    vectors++;
    if (free_count !== 6'd32) begin
      miscompares++;
      $display("[TB] FAIL reset_free_count: got %0d expected 32", free_count);
    end
    vectors++;
    if (not_full !== 1'b1 || not_empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got nf=%b ne=%b expected nf=1 ne=0", not_full, not_empty);
    end
  endtask

  task automatic test_basic_line();
    logic [127:0] a [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a[i] = rand_block();
      vectors++;
      if (not_empty !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL basic_early_not_empty: got %b expected 0 after %0d blocks", not_empty, i);
      end
      applyStimulus(1'b1, a[i], 1'b0, 1'b0);
    end
    vectors++;
    if (not_empty !== 1'b1 || counter !== 6'd4) begin
      miscompares++;
      $display("[TB] FAIL basic_not_empty: got ne=%b cnt=%0d expected ne=1 cnt=4", not_empty, counter);
    end
    vectors++;
    if (deq_data !== {a[3], a[2], a[1], a[0]}) begin
      miscompares++;
      $display("[TB] FAIL basic_line: got %h expected %h", deq_data, {a[3], a[2], a[1], a[0]});
    end
    vectors++;
    if (deq_mask !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL basic_mask: got %h expected f", deq_mask);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (counter !== 6'd0 || not_empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_after_deq: got cnt=%0d ne=%b expected cnt=0 ne=0", counter, not_empty);
    end
  endtask

  task automatic test_fill_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, rand_block(), 1'b0, 1'b0);
    vectors++;
    if (counter !== 6'd32 || not_full !== 1'b0 || free_count !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL full_state: got cnt=%0d nf=%b free=%0d expected cnt=32 nf=0 free=0",
               counter, not_full, free_count);
    end
    applyStimulus(1'b1, rand_block(), 1'b0, 1'b0);
    vectors++;
    if (counter !== 6'd32) begin
      miscompares++;
      $display("[TB] FAIL full_drop: got cnt=%0d expected 32", counter);
    end
  endtask

  // Runs from the full state left by test_fill_full.
  task automatic test_full_simul();
    int guard;
    vectors++;
    if (deq_data !== exp_line()) begin
      miscompares++;
      $display("[TB] FAIL full_simul_line: got %h expected %h", deq_data, exp_line());
    end
    applyStimulus(1'b1, rand_block(), 1'b1, 1'b0);
    vectors++;
    if (counter !== 6'd28 || not_full !== 1'b1 || free_count !== 6'd4) begin
      miscompares++;
      $display("[TB] FAIL full_simul_count: got cnt=%0d nf=%b free=%0d expected cnt=28 nf=1 free=4",
               counter, not_full, free_count);
    end
    guard = 0;
    while (sb_data.size() >= 4 && guard < 64) begin
      guard++;
      vectors++;
      if (not_empty !== 1'b1 || deq_data !== exp_line()) begin
        miscompares++;
        $display("[TB] FAIL full_drain: got ne=%b %h expected ne=1 %h", not_empty, deq_data, exp_line());
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
    vectors++;
    if (counter !== CW'(sb_data.size()) || not_empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_drain_end: got cnt=%0d ne=%b expected cnt=%0d ne=0",
               counter, not_empty, sb_data.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, rand_block(), 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (sb_data.size() >= 4) begin
        vectors++;
        if (deq_data !== exp_line() || deq_mask !== exp_mask()) begin
          miscompares++;
          $display("[TB] FAIL b2b_line[%0d]: got %h/%h expected %h/%h",
                   i, deq_data, deq_mask, exp_line(), exp_mask());
        end
      end
      applyStimulus(1'b1, rand_block(), 1'b1, 1'b0);
      vectors++;
      if (counter !== CW'(sb_data.size()) || not_empty !== (sb_data.size() >= 4)) begin
        miscompares++;
        $display("[TB] FAIL b2b_count[%0d]: got cnt=%0d ne=%b expected cnt=%0d",
                 i, counter, not_empty, sb_data.size());
      end
    end
    while (sb_data.size() >= 4) begin
      vectors++;
      if (deq_data !== exp_line()) begin
        miscompares++;
        $display("[TB] FAIL b2b_drain: got %h expected %h", deq_data, exp_line());
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush();
    logic [127:0] b0, b1, b2, b3;
    do_reset();
    b0 = rand_block();
    b1 = rand_block();
    applyStimulus(1'b1, b0, 1'b0, 1'b0);
    applyStimulus(1'b1, b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
`ifdef AES128_PACK_FLUSH_EN
    vectors++;
    if (counter !== 6'd4 || not_empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_count: got cnt=%0d ne=%b expected cnt=4 ne=1", counter, not_empty);
    end
    vectors++;
    if (deq_data !== {128'h0, 128'h0, b1, b0} || deq_mask !== 4'b0011) begin
      miscompares++;
      $display("[TB] FAIL flush_line: got %h/%h expected %h/3",
               deq_data, deq_mask, {128'h0, 128'h0, b1, b0});
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (counter !== 6'd4) begin
      miscompares++;
      $display("[TB] FAIL flush_aligned_noop: got cnt=%0d expected 4", counter);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    b2 = rand_block();
    b3 = rand_block();
    applyStimulus(1'b1, b2, 1'b0, 1'b0);
    applyStimulus(1'b1, b3, 1'b0, 1'b1);
    vectors++;
    if (counter !== 6'd2) begin
      miscompares++;
      $display("[TB] FAIL flush_enq_priority: got cnt=%0d expected 2", counter);
    end
`else
    vectors++;
    if (counter !== 6'd2 || not_empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_ignored: got cnt=%0d ne=%b expected cnt=2 ne=0", counter, not_empty);
    end
    b2 = rand_block();
    b3 = rand_block();
    applyStimulus(1'b1, b2, 1'b0, 1'b0);
    applyStimulus(1'b1, b3, 1'b0, 1'b0);
    vectors++;
    if (deq_data !== {b3, b2, b1, b0} || deq_mask !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL flush_ignored_line: got %h/%h expected %h/f",
               deq_data, deq_mask, {b3, b2, b1, b0});
    end
`endif
  endtask

  task automatic test_reset_midline();
    logic [127:0] c [4];
    do_reset();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, rand_block(), 1'b0, 1'b0);
    do_reset();
    vectors++;
    if (counter !== 6'd0 || not_empty !== 1'b0 || free_count !== 6'd32) begin
      miscompares++;
      $display("[TB] FAIL midline_reset: got cnt=%0d ne=%b free=%0d expected 0/0/32",
               counter, not_empty, free_count);
    end
    for (int i = 0; i < 4; i++) begin
      c[i] = rand_block();
      applyStimulus(1'b1, c[i], 1'b0, 1'b0);
    end
    vectors++;
    if (not_empty !== 1'b1 || deq_data !== {c[3], c[2], c[1], c[0]} || deq_mask !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL midline_line: got ne=%b %h/%h expected ne=1 %h/f",
               not_empty, deq_data, deq_mask, {c[3], c[2], c[1], c[0]});
    end
  endtask

  initial begin
    reset    = 1'b1;
    enq_en   = 1'b0;
    deq_en   = 1'b0;
    flush    = 1'b0;
    enq_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_line();
    test_fill_full();
    test_full_simul();
    test_back_to_back();
    test_flush();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
